// File: rtl/control_seq_if.sv
// Command/status bundle between the sequencer and its datapath driver.
// master drives requests and Y's LSB; slave returns commands and status.
interface control_seq_if #(
    parameter int CMD_W = 4
) ();
    logic             start;
    logic [2:0]       opcode;
    logic             y_lsb;
    logic [CMD_W-1:0] tx;
    logic [CMD_W-1:0] ty;
    logic [CMD_W-1:0] tz;
    logic [CMD_W-1:0] tula;
    logic [3:0]       current_state;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, opcode, y_lsb,
        input  tx, ty, tz, tula, current_state, busy, done, err
    );

    modport slave (
        input  start, opcode, y_lsb,
        output tx, ty, tz, tula, current_state, busy, done, err
    );
endinterface

// File: rtl/control_seq.sv
// Control sequencer for an add/sub/shift-add-multiply datapath.
// Emits per-cycle register and ALU commands from a registered FSM.
module control_seq #(
    parameter int WIDTH = 4,
    parameter int CMD_W = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    control_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [CMD_W-1:0] C_CLEAR  = CMD_W'(0);
    localparam logic [CMD_W-1:0] C_LOAD   = CMD_W'(1);
    localparam logic [CMD_W-1:0] C_HOLD   = CMD_W'(2);
    localparam logic [CMD_W-1:0] C_SHIFTR = CMD_W'(3);
    localparam logic [CMD_W-1:0] C_SHIFTL = CMD_W'(4);
    localparam logic [CMD_W-1:0] A_ADD    = CMD_W'(0);
    localparam logic [CMD_W-1:0] A_SUB    = CMD_W'(1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LOADX     = 4'd1,
        S_LOADY     = 4'd2,
        S_EXEC      = 4'd3,
        S_MUL_ADD   = 4'd4,
        S_MUL_SHIFT = 4'd5,
        S_DONE      = 4'd7
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_op;
    logic [CW-1:0] r_cnt;
    logic          w_last;
    logic          w_accept;

    assign w_last   = (r_cnt == LAST);
    assign w_accept = (r_state == S_IDLE) && bus.start;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_op    <= 3'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept)
                r_op <= bus.opcode;
            if (r_state == S_LOADY)
                r_cnt <= '0;
            else if (r_state == S_MUL_SHIFT && !w_last)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (!bus.start)
                    w_next = S_IDLE;
                else if (bus.opcode <= 3'd2)
                    w_next = S_LOADX;
                else
                    w_next = S_DONE;
            end
            S_LOADX:     w_next = S_LOADY;
            S_LOADY:     w_next = (r_op == 3'd2) ? S_MUL_ADD : S_EXEC;
            S_EXEC:      w_next = S_DONE;
            S_MUL_ADD:   w_next = S_MUL_SHIFT;
            S_MUL_SHIFT: w_next = w_last ? S_DONE : S_MUL_ADD;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.tx   = C_HOLD;
        bus.ty   = C_HOLD;
        bus.tz   = C_HOLD;
        bus.tula = A_ADD;
        bus.busy = (r_state != S_IDLE);
        bus.done = 1'b0;
        bus.err  = 1'b0;
        case (r_state)
            S_LOADX: bus.tx = C_LOAD;
            S_LOADY: begin
                bus.ty = C_LOAD;
                bus.tz = C_CLEAR;
            end
            S_EXEC: begin
                bus.tz   = C_LOAD;
                bus.tula = (r_op == 3'd1) ? A_SUB : A_ADD;
            end
            S_MUL_ADD: bus.tz = bus.y_lsb ? C_LOAD : C_HOLD;
            S_MUL_SHIFT: begin
                bus.tx = C_SHIFTL;
                bus.ty = C_SHIFTR;
            end
            S_DONE: begin
                bus.done = 1'b1;
                bus.err  = (r_op > 3'd2);
            end
            default: ;
        endcase
        // Reset forces the datapath clear regardless of the stored state.
        if (!reset_n) begin
            bus.tx   = C_CLEAR;
            bus.ty   = C_CLEAR;
            bus.tz   = C_CLEAR;
            bus.tula = A_ADD;
            bus.busy = 1'b0;
            bus.done = 1'b0;
            bus.err  = 1'b0;
        end
    end

    assign bus.current_state = r_state;
endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq: reset, ADD/SUB/MUL, invalid opcode,
// mid-multiply reset and back-to-back start.
module tb_control_seq;
    logic clock;
    logic reset_n;
    int   total;
    int   bad;
    int   nshift;
    int   cyc;
    logic [3:0] pat;

    control_seq_if #(.CMD_W(4)) bus ();

    control_seq #(.WIDTH(4), .CMD_W(4)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.opcode = 3'd0;
        bus.y_lsb = 1'b0;
        #1;
        chk("rst_tx", 32'(bus.tx), 32'd0);
        chk("rst_ty", 32'(bus.ty), 32'd0);
        chk("rst_tz", 32'(bus.tz), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("rst_state", 32'(bus.current_state), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("idle_tx", 32'(bus.tx), 32'd2);
        chk("idle_tz", 32'(bus.tz), 32'd2);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("idle_rest", 32'(bus.current_state), 32'd0);

        // ADD, opcode disturbed after acceptance
        bus.start = 1'b1;
        bus.opcode = 3'd0;
        tick();
        bus.start = 1'b0;
        bus.opcode = 3'd3;
        chk("add_s1", 32'(bus.current_state), 32'd1);
        chk("add_tx", 32'(bus.tx), 32'd1);
        tick();
        chk("add_s2", 32'(bus.current_state), 32'd2);
        chk("add_ty", 32'(bus.ty), 32'd1);
        chk("add_tz_clr", 32'(bus.tz), 32'd0);
        tick();
        chk("add_s3", 32'(bus.current_state), 32'd3);
        chk("add_tz", 32'(bus.tz), 32'd1);
        chk("add_tula", 32'(bus.tula), 32'd0);
        tick();
        chk("add_s7", 32'(bus.current_state), 32'd7);
        chk("add_done", 32'(bus.done), 32'd1);
        chk("add_err", 32'(bus.err), 32'd0);
        tick();
        chk("add_s0", 32'(bus.current_state), 32'd0);
        chk("add_done0", 32'(bus.done), 32'd0);

        // SUB
        bus.start = 1'b1;
        bus.opcode = 3'd1;
        tick();
        bus.start = 1'b0;
        bus.opcode = 3'd0;
        chk("sub_s1", 32'(bus.current_state), 32'd1);
        tick();
        tick();
        chk("sub_s3", 32'(bus.current_state), 32'd3);
        chk("sub_tula", 32'(bus.tula), 32'd1);
        chk("sub_err3", 32'(bus.err), 32'd0);
        tick();
        chk("sub_s7", 32'(bus.current_state), 32'd7);
        chk("sub_err7", 32'(bus.err), 32'd0);
        chk("sub_tula7", 32'(bus.tula), 32'd0);
        tick();
        chk("sub_s0", 32'(bus.current_state), 32'd0);

        // MUL, y_lsb 1,0,1,1
        pat = 4'b1101;
        nshift = 0;
        cyc = 0;
        bus.start = 1'b1;
        bus.opcode = 3'd2;
        tick();
        cyc++;
        bus.start = 1'b0;
        chk("mul_s1", 32'(bus.current_state), 32'd1);
        tick();
        cyc++;
        chk("mul_s2", 32'(bus.current_state), 32'd2);
        for (int i = 0; i < 4; i++) begin
            tick();
            cyc++;
            bus.y_lsb = pat[i];
            #1;
            chk("mul_sadd", 32'(bus.current_state), 32'd4);
            chk("mul_tz", 32'(bus.tz), pat[i] ? 32'd1 : 32'd2);
            chk("mul_tula", 32'(bus.tula), 32'd0);
            tick();
            cyc++;
            if (bus.current_state == 4'd5) nshift++;
            chk("mul_tx", 32'(bus.tx), 32'd4);
            chk("mul_ty", 32'(bus.ty), 32'd3);
            chk("mul_tzh", 32'(bus.tz), 32'd2);
        end
        tick();
        cyc++;
        chk("mul_nshift", 32'(nshift), 32'd4);
        chk("mul_s7", 32'(bus.current_state), 32'd7);
        chk("mul_lat", 32'(cyc), 32'd11);
        chk("mul_done", 32'(bus.done), 32'd1);
        tick();
        chk("mul_s0", 32'(bus.current_state), 32'd0);

        // invalid opcode
        bus.start = 1'b1;
        bus.opcode = 3'd5;
        tick();
        bus.start = 1'b0;
        chk("inv_s7", 32'(bus.current_state), 32'd7);
        chk("inv_done", 32'(bus.done), 32'd1);
        chk("inv_err", 32'(bus.err), 32'd1);
        chk("inv_tx", 32'(bus.tx), 32'd2);
        chk("inv_ty", 32'(bus.ty), 32'd2);
        chk("inv_tz", 32'(bus.tz), 32'd2);
        tick();
        chk("inv_s0", 32'(bus.current_state), 32'd0);
        chk("inv_err0", 32'(bus.err), 32'd0);

        // reset during MUL_SHIFT with counter=2
        bus.y_lsb = 1'b0;
        bus.start = 1'b1;
        bus.opcode = 3'd2;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("mr_s5", 32'(bus.current_state), 32'd5);
        reset_n = 1'b0;
        #1;
        chk("mr_tx", 32'(bus.tx), 32'd0);
        chk("mr_ty", 32'(bus.ty), 32'd0);
        chk("mr_tz", 32'(bus.tz), 32'd0);
        chk("mr_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("mr_s0", 32'(bus.current_state), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("mr_hold", 32'(bus.tx), 32'd2);
        chk("mr_tzh", 32'(bus.tz), 32'd2);
        tick();
        chk("mr_idle", 32'(bus.current_state), 32'd0);

        // start held high through ADD
        bus.start = 1'b1;
        bus.opcode = 3'd0;
        tick();
        chk("b2b_s1", 32'(bus.current_state), 32'd1);
        tick();
        chk("b2b_s2", 32'(bus.current_state), 32'd2);
        tick();
        chk("b2b_s3", 32'(bus.current_state), 32'd3);
        tick();
        chk("b2b_s7", 32'(bus.current_state), 32'd7);
        tick();
        chk("b2b_s0", 32'(bus.current_state), 32'd0);
        tick();
        chk("b2b_again", 32'(bus.current_state), 32'd1);
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("b2b_end", 32'(bus.current_state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/control_seq.md
CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 Parameter: WIDTH, 4, datapath operand width in bits; sets multiply iteration count; legal range 2..16.
REQ-002 Parameter: CMD_W, 4, width of each register and ALU command output.
REQ-003 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset_n  input  1  reset is synchronous and active-low.
REQ-005 Port: start  input  1  request to run one operation; sampled only in IDLE.
REQ-006 Port: opcode  input  3  operation select (0 ADD, 1 SUB, 2 MUL, 3..7 invalid); captured when start is accepted.
REQ-007 Port: y_lsb  input  1  bit 0 of datapath register Y; used only in MUL_ADD.
REQ-008 Port: tx, ty, tz  output  CMD_W each  register commands: CLEAR=0, LOAD=1, HOLD=2, SHIFTR=3, SHIFTL=4.
REQ-009 Port: tula  output  CMD_W  ALU command: ADD=0, SUB=1.
REQ-010 Port: current_state  output  4  encoded FSM state.
REQ-011 Port: busy  output  1  high in every state except IDLE.
REQ-012 Port: done  output  1  high only while in DONE.
REQ-013 Port: err  output  1  high only while in DONE when the captured opcode is invalid.

Function
REQ-014 The block SHALL implement states IDLE=0, LOADX=1, LOADY=2, EXEC=3, MUL_ADD=4, MUL_SHIFT=5, DONE=7; encodings 6 and 8..15 SHALL go to IDLE on the next edge.
REQ-015 current_state, the captured opcode, and the iteration counter (clog2(WIDTH) bits) SHALL be registered.
REQ-016 tx/ty/tz/tula/busy/done/err SHALL be a combinational decode of the registered state, the captured opcode, and (in MUL_ADD only) y_lsb.
REQ-017 IDLE: all commands HOLD, tula ADD; start=1 with opcode 0..2 -> LOADX; start=1 with opcode 3..7 -> DONE with err; start=0 -> stay in IDLE.
REQ-018 LOADX: tx LOAD, ty HOLD, tz HOLD; -> LOADY.
REQ-019 LOADY: tx HOLD, ty LOAD, tz CLEAR; -> EXEC for ADD/SUB; -> MUL_ADD with counter=0 for MUL.
REQ-020 EXEC: tx HOLD, ty HOLD, tz LOAD; tula ADD for opcode 0, SUB for opcode 1; -> DONE.
REQ-021 MUL_ADD: tx HOLD, ty HOLD, tula ADD; tz LOAD if y_lsb=1, else HOLD; -> MUL_SHIFT.
REQ-022 MUL_SHIFT: tx SHIFTL, ty SHIFTR, tz HOLD; if counter==WIDTH-1 -> DONE, else increment counter and go to MUL_ADD.
REQ-023 DONE: all commands HOLD; -> IDLE unconditionally.
REQ-024 start SHALL be ignored outside IDLE; opcode changes after acceptance SHALL have no effect.
REQ-025 Latency, counted from the accepting edge to the edge entering DONE:
- ADD/SUB: 4 cycles.
- MUL: 2*WIDTH+3 cycles.
- Invalid opcode: 1 cycle.
REQ-026 Back-to-back operation: after DONE the FSM returns to IDLE; the next start is accepted no earlier than 2 cycles after the edge entering DONE.
REQ-027 tula outside EXEC and MUL_ADD SHALL be ADD.

Reset
REQ-028 While reset_n=0, the combinational outputs SHALL be tx=ty=tz=CLEAR, tula=ADD, busy=0, done=0, err=0.
REQ-029 The rising clock edge with reset_n=0 SHALL set current_state=IDLE, counter=0, and captured opcode=0, in any state, including mid-multiply.
REQ-030 With reset_n=1 and start=0, the block SHALL rest in IDLE with all commands HOLD.

Verification
REQ-031 Reset asserted during MUL_SHIFT, counter=2 -> current_state=0 on the next edge; outputs CLEAR/CLEAR/CLEAR while reset_n=0; HOLD after release.
REQ-032 start=1, opcode=0 -> state sequence 1,2,3,7,0; done pulses exactly one cycle; in EXEC tz=LOAD, tula=ADD.
REQ-033 opcode=1, held at 0 after acceptance -> EXEC shows tula=SUB; err=0 throughout.
REQ-034 WIDTH=4, opcode=2, y_lsb pattern 1,0,1,1 across MUL_ADD visits:
- tz=LOAD, HOLD, LOAD, LOAD in those visits.
- Exactly 4 MUL_SHIFT cycles with tx=SHIFTL, ty=SHIFTR.
- DONE reached 11 cycles after acceptance.
REQ-035 opcode=5 with start -> DONE next cycle with done=1, err=1, all commands HOLD; then IDLE.
REQ-036 start held high continuously through an ADD operation:
- No re-acceptance while busy.
- Second operation accepted at the first IDLE edge, which is 2 cycles after entering DONE.
